// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared state encoding and default constants
// for the square-wave period / high-time meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    TIMED_OUT  = 2'd2
  } fm_state_e;

  localparam int FM_CNT_W   = 26;
  localparam int FM_CLK_HZ  = 12_000_000;
  localparam int FM_TIMEOUT = 30_000_000;

endpackage

// File: rtl/freq_meter_edge_sync.sv
// edge_sync: two-flop synchroniser plus history flop,
// giving single-cycle rise/fall strobes in the clk_in domain.
module edge_sync (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = sig_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: measures rise-to-rise period and rise-to-fall high
// time of sig_in in clk_in cycles, with a no-edge timeout.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CNT_W          = FM_CNT_W,
  parameter int TIMEOUT_CYCLES = FM_TIMEOUT
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic             rise, fall;
  fm_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  edge_sync u_sync (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .sig_in   (sig_in),
    .rise     (rise),
    .fall     (fall)
  );

  assign cnt_inc = cnt_q + ONE;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_cap_d  = hi_cap_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    case (state_q)
      WAIT_FIRST: begin
        cnt_d     = '0;
        timeout_d = 1'b0;
        if (rise) state_d = MEASURE;
      end
      MEASURE: begin
        cnt_d     = cnt_inc;
        timeout_d = 1'b0;
        if (fall) hi_cap_d = cnt_inc;
        // A rise in the timeout cycle still completes the period.
        if (rise) begin
          period_d = cnt_inc;
          high_d   = hi_cap_q;
          valid_d  = 1'b1;
          cnt_d    = '0;
        end else if (cnt_inc == TO_CNT) begin
          state_d   = TIMED_OUT;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end
      end
      TIMED_OUT: begin
        cnt_d     = '0;
        timeout_d = 1'b1;
        if (rise) begin
          timeout_d = 1'b0;
          state_d   = MEASURE;
        end
      end
      default: begin
        state_d   = WAIT_FIRST;
        cnt_d     = '0;
        timeout_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= WAIT_FIRST;
      cnt_q     <= '0;
      hi_cap_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_cap_q  <= hi_cap_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period_out = period_q;
  assign high_out   = high_q;
  assign meas_valid = valid_q;
  assign timeout    = timeout_q;

endmodule
